render_pipe: RTL and testbench

- Parametrised successor of the brick-game pixel renderer. Same raster position (x, y) and game objects in; 9-bit VGA colour out.
- Adds a configurable brick grid, N independent balls, strict layer priority instead of OR-merging, and a 2-stage posedge-only pipeline.
- Adds a timed hit-flash animation on one brick.
- Sits between the VGA timing generator and the DAC pins; the game-logic block drives object positions.

---
 rtl/render_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_render_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_pipe.sv
// Two-stage VGA pixel renderer: a brick grid, N balls, an aiming ghost and paddles, merged by strict layer priority.
// Optional grey screen border when RENDER_BORDER_EN is defined.
module render_pipe #(
   parameter int BRICK_COLS   = 8,
   parameter int BRICK_ROWS   = 8,
   parameter int BRICK_W      = 100,
   parameter int BRICK_H      = 50,
   parameter int GAP          = 5,
   parameter int PADDLE_LEN   = 80,
   parameter int RADIUS       = 4,
   parameter int N_BALLS      = 2,
   parameter int TWO_PLAYER   = 0,
   parameter int FLASH_FRAMES = 8,
   localparam int ID_W        = $clog2(BRICK_COLS*BRICK_ROWS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [10:0]                       x,
   input  logic [9:0]                        y,
   input  logic                              o_active,
   input  logic                              frame_start,
   input  logic [2:0]                        state,
   input  logic [2:0]                        angle,
   input  logic [10:0]                       x_paddle_l,
   input  logic [10:0]                       x_paddle_r,
   input  logic [11*N_BALLS-1:0]             ball_x,
   input  logic [10*N_BALLS-1:0]             ball_y,
   input  logic [N_BALLS-1:0]                ball_en,
   input  logic [2*BRICK_COLS*BRICK_ROWS-1:0] brick,
   input  logic                              hit_valid,
   input  logic [ID_W-1:0]                   hit_id,
   output logic [8:0]                        VGA,
   output logic                              vga_valid
);
   localparam int CB = $clog2(BRICK_COLS);
   localparam int RB = $clog2(BRICK_ROWS);

   function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   function automatic logic [11:0] sat_sub(input logic [11:0] a, input logic [11:0] b);
      return (a >= b) ? (a - b) : 12'd0;
   endfunction

   function automatic logic [10:0] sat_top(input logic [11:0] v);
      return (v > 12'd2047) ? 11'd2047 : v[10:0];
   endfunction

   // Rounded-square ball outline: corners of the bounding box are trimmed off.
   function automatic logic shape_hit(input logic [11:0] dx, input logic [11:0] dy);
      logic near;
      near = (dx <= 12'(RADIUS)) && (dy <= 12'(RADIUS));
      return near && ((dx == 12'd0) || (dy == 12'd0) ||
                      ((dx <= 12'd2) && (dy <= 12'd3)) ||
                      ((dy <= 12'd2) && (dx <= 12'd3)));
   endfunction

   function automatic logic in_paddle(input logic [11:0] px, input logic [10:0] xp);
      return (px >= sat_sub({1'b0, xp}, 12'(PADDLE_LEN))) &&
             (px <= ({1'b0, xp} + 12'(PADDLE_LEN)));
   endfunction

   logic [11:0] x12, y12, gx, gy;
   logic        ball_s, ghost_s, padr_s, padl_s, act_s;
   logic [10:0] col, xo;
   logic [9:0]  row, yo;
   logic [ID_W-1:0] bid_s;
   logic [1:0]  btype_s;

   assign x12 = {1'b0, x};
   assign y12 = {2'b0, y};

   always_comb begin
      ball_s = 1'b0;
      for (int i = 0; i < N_BALLS; i++) begin
         if (ball_en[i] &&
             shape_hit(abs_diff(x12, {1'b0, ball_x[11*i +: 11]}),
                       abs_diff(y12, {2'b0, ball_y[10*i +: 10]})))
            ball_s = 1'b1;
      end
   end

   assign gx = (angle == 3'd1) ? sat_sub({1'b0, ball_x[10:0]}, 12'd20)
                               : {1'b0, sat_top({1'b0, ball_x[10:0]} + 12'd20)};
   assign gy = sat_sub({2'b0, ball_y[9:0]}, 12'd20);
   assign ghost_s = (state == 3'd2) && ball_en[0] &&
                    shape_hit(abs_diff(x12, gx), abs_diff(y12, gy));

   assign padr_s = in_paddle(x12, x_paddle_r) && (y > 10'd570) && (y <= 10'd580);
   assign padl_s = (TWO_PLAYER == 1) && in_paddle(x12, x_paddle_l) &&
                   (y > 10'd20) && (y <= 10'd30);

   assign col   = x / 11'(BRICK_W);
   assign row   = y / 10'(BRICK_H);
   assign xo    = x - col * 11'(BRICK_W);
   assign yo    = y - row * 10'(BRICK_H);
   assign bid_s = {row[RB-1:0], col[CB-1:0]};

   always_comb begin
      btype_s = 2'b00;
      if ((col < 11'(BRICK_COLS)) && (row < 10'(BRICK_ROWS)) &&
          (xo >= 11'(GAP)) && (xo < 11'(BRICK_W - GAP)) &&
          (yo >= 10'(GAP)) && (yo < 10'(BRICK_H - GAP)))
         btype_s = brick[{bid_s, 1'b0} +: 2];
   end

   assign act_s = o_active && (x != 11'd0) && (y != 10'd0) && (state >= 3'd2);

   // Flash state: a hit reloads the counter, frame starts count it down and flip parity.
   logic [7:0]      flash_cnt;
   logic [ID_W-1:0] flash_id;
   logic            frame_par;

   always_ff @(posedge clk) begin
      if (!rst) begin
         flash_cnt <= 8'd0;
         flash_id  <= '0;
         frame_par <= 1'b0;
      end else begin
         if (hit_valid) begin
            flash_cnt <= 8'(FLASH_FRAMES);
            flash_id  <= hit_id;
         end else if (frame_start && (flash_cnt != 8'd0)) begin
            flash_cnt <= flash_cnt - 8'd1;
         end
         if (frame_start)
            frame_par <= ~frame_par;
      end
   end

   // Stage 1: per-layer hit flags
   logic            act_p1, vld_p1, ball_p1, ghost_p1, padr_p1, padl_p1;
   logic [1:0]      btype_p1;
   logic [ID_W-1:0] bid_p1;
`ifdef RENDER_BORDER_EN
   logic            border_s, border_p1;
   assign border_s = (x <= 11'd2) || (x >= 11'd797) || (y <= 10'd2);
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         act_p1   <= 1'b0;
         vld_p1   <= 1'b0;
         ball_p1  <= 1'b0;
         ghost_p1 <= 1'b0;
         padr_p1  <= 1'b0;
         padl_p1  <= 1'b0;
         btype_p1 <= 2'b00;
         bid_p1   <= '0;
`ifdef RENDER_BORDER_EN
         border_p1 <= 1'b0;
`endif
      end else begin
         act_p1   <= act_s;
         vld_p1   <= o_active;
         ball_p1  <= ball_s;
         ghost_p1 <= ghost_s;
         padr_p1  <= padr_s;
         padl_p1  <= padl_s;
         btype_p1 <= btype_s;
         bid_p1   <= bid_s;
`ifdef RENDER_BORDER_EN
         border_p1 <= border_s;
`endif
      end
   end

   // Stage 2: priority mux
   logic [8:0] pix_s;

   always_comb begin
      pix_s = 9'b000000000;
      if (!act_p1)
         pix_s = 9'b000000000;
      else if (ball_p1)
         pix_s = 9'b111111111;
      else if (ghost_p1)
         pix_s = 9'b010010010;
      else if (padr_p1)
         pix_s = 9'b111000000;
      else if (padl_p1)
         pix_s = 9'b000000111;
      else if ((btype_p1 != 2'b00) && (flash_cnt != 8'd0) && (bid_p1 == flash_id))
         pix_s = frame_par ? 9'b000000000 : 9'b111111111;
      else if (btype_p1 == 2'd1)
         pix_s = 9'b111111111;
      else if (btype_p1 == 2'd2)
         pix_s = 9'b111000000;
      else if (btype_p1 == 2'd3)
         pix_s = 9'b000111111;
`ifdef RENDER_BORDER_EN
      else if (border_p1)
         pix_s = 9'b001001001;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         VGA       <= 9'd0;
         vga_valid <= 1'b0;
      end else begin
         VGA       <= pix_s;
         vga_valid <= vld_p1;
      end
   end
endmodule

// File: tb/tb_render_pipe.sv
// Self-checking bench for render_pipe: directed scenarios plus randomized pixels
// compared against a rule-level colour model.
module tb_render_pipe;
   localparam int COLS = 8, ROWS = 8, BW = 100, BH = 50, GP = 5;
   localparam int PL = 80, R = 4, NB = 2, FF = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [10:0]   x = '0;
   logic [9:0]    y = '0;
   logic          o_active = 1'b0;
   logic          frame_start = 1'b0;
   logic [2:0]    state = '0;
   logic [2:0]    angle = '0;
   logic [10:0]   x_paddle_l = 11'd1000;
   logic [10:0]   x_paddle_r = 11'd1000;
   logic [21:0]   ball_x = '0;
   logic [19:0]   ball_y = '0;
   logic [1:0]    ball_en = '0;
   logic [127:0]  brick = '0;
   logic          hit_valid = 1'b0;
   logic [5:0]    hit_id = '0;
   logic [8:0]    VGA;
   logic          vga_valid;

   int vectors = 0;
   int miscompares = 0;
   int m_cnt = 0, m_id = 0, m_par = 0;

   render_pipe dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .o_active(o_active),
      .frame_start(frame_start), .state(state), .angle(angle),
      .x_paddle_l(x_paddle_l), .x_paddle_r(x_paddle_r),
      .ball_x(ball_x), .ball_y(ball_y), .ball_en(ball_en), .brick(brick),
      .hit_valid(hit_valid), .hit_id(hit_id), .VGA(VGA), .vga_valid(vga_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d)", tag, obs, exp, x, y);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic bit ball_shape(input int dx, input int dy);
      int ax = iabs(dx), ay = iabs(dy);
      if (ax > R || ay > R) return 0;
      return (ax == 0) || (ay == 0) || (ax <= 2 && ay <= 3) || (ay <= 2 && ax <= 3);
   endfunction

   function automatic int model_pix();
      int px = int'(x), py = int'(y);
      int gx, gy, lo, col, row, t, id;
      if (!(o_active && px > 0 && py > 0 && state >= 2)) return 0;
      for (int i = 0; i < NB; i++)
         if (ball_en[i] && ball_shape(px - int'(ball_x[11*i +: 11]), py - int'(ball_y[10*i +: 10])))
            return 'h1FF;
      if (state == 2 && ball_en[0]) begin
         gx = (angle == 1) ? int'(ball_x[10:0]) - 20 : int'(ball_x[10:0]) + 20;
         if (gx < 0) gx = 0;
         if (gx > 2047) gx = 2047;
         gy = int'(ball_y[9:0]) - 20;
         if (gy < 0) gy = 0;
         if (ball_shape(px - gx, py - gy)) return 'h092;
      end
      lo = int'(x_paddle_r) - PL;
      if (lo < 0) lo = 0;
      if (px >= lo && px <= int'(x_paddle_r) + PL && py > 570 && py <= 580) return 'h1C0;
      col = px / BW;
      row = py / BH;
      if (col < COLS && row < ROWS && (px % BW) >= GP && (px % BW) < BW - GP &&
          (py % BH) >= GP && (py % BH) < BH - GP) begin
         id = row * COLS + col;
         t = int'(brick[2*id +: 2]);
         if (t != 0) begin
            if (m_cnt != 0 && id == m_id) return m_par ? 0 : 'h1FF;
            case (t)
               1: return 'h1FF;
               2: return 'h1C0;
               default: return 'h03F;
            endcase
         end
      end
`ifdef RENDER_BORDER_EN
      if (px <= 2 || px >= 797 || py <= 2) return 'h049;
`endif
      return 0;
   endfunction

   task automatic probe(input int xv, input int yv);
      x = 11'(xv);
      y = 10'(yv);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic probe_model(input string tag, input int xv, input int yv);
      probe(xv, yv);
      check(tag, int'(VGA), model_pix());
      check({tag, "_valid"}, int'(vga_valid), int'(o_active));
   endtask

   task automatic pulse(input bit hit, input bit frame, input int id);
      hit_valid = hit;
      frame_start = frame;
      hit_id = 6'(id);
      @(posedge clk);
      #1;
      hit_valid = 1'b0;
      frame_start = 1'b0;
      if (hit) begin
         m_cnt = FF;
         m_id = id;
      end else if (frame && m_cnt > 0) begin
         m_cnt--;
      end
      if (frame) m_par ^= 1;
   endtask

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : (v > hi) ? hi : v;
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_vga", int'(VGA), 0);
      check("reset_valid", int'(vga_valid), 0);
      check("reset_flash_cnt", int'(dut.flash_cnt), 0);
      rst = 1'b1;

      // Ball layer
      o_active = 1'b1;
      state = 3'd3;
      ball_x = {11'd0, 11'd400};
      ball_y = {10'd0, 10'd300};
      ball_en = 2'b01;
      probe(400, 300);
      check("ball_centre", int'(VGA), 'h1FF);
      check("ball_valid", int'(vga_valid), 1);
      probe(404, 304);
      check("ball_corner", int'(VGA), 0);
      probe(404, 301);
      check("ball_edge", int'(VGA), 0);
      probe(403, 302);
      check("ball_edge_in", int'(VGA), 'h1FF);

      // Ghost only while aiming
      state = 3'd2;
      angle = 3'd1;
      probe(380, 280);
      check("ghost_left", int'(VGA), 'h092);
      state = 3'd3;
      probe(380, 280);
      check("ghost_playing", int'(VGA), 0);
      state = 3'd1;
      probe(400, 300);
      check("blank_state", int'(VGA), 0);
      check("blank_valid", int'(vga_valid), 1);

      // Brick grid
      state = 3'd3;
      ball_en = 2'b00;
      brick[19:18] = 2'd2;
      probe(150, 60);
      check("brick9", int'(VGA), 'h1C0);
      probe(104, 60);
      check("brick_gap", int'(VGA), 0);
      probe(150, 420);
      check("brick_row8", int'(VGA), 0);

      // Paddle at left edge: no wraparound
      x_paddle_r = 11'd40;
      for (int i = 0; i <= 120; i++) begin
         probe(i, 575);
         check("paddle_sweep", int'(VGA), (i == 0) ? 0 : 'h1C0);
      end
      probe(2040, 575);
      check("paddle_nowrap", int'(VGA), 0);
      probe(60, 570);
      check("paddle_ytop", int'(VGA), 0);
      ball_x = {11'd60, 11'd400};
      ball_y = {10'd575, 10'd300};
      ball_en = 2'b10;
      probe(60, 575);
      check("ball_over_paddle", int'(VGA), 'h1FF);
      ball_en = 2'b00;
      x_paddle_r = 11'd1000;

      // Flash on brick 9
      pulse(1, 0, 9);
      for (int f = 0; f <= 8; f++) begin
         probe(150, 60);
         check("flash_seq", int'(VGA), model_pix());
         if (f == 0) check("flash_white", int'(VGA), 'h1FF);
         if (f == 1) check("flash_black", int'(VGA), 0);
         if (f == 8) check("flash_done", int'(VGA), 'h1C0);
         if (f < 8) pulse(0, 1, 0);
      end
      pulse(1, 1, 9);
      check("hit_and_frame_cnt", int'(dut.flash_cnt), 8);
      pulse(0, 1, 0);
      probe(150, 60);
      check("flash_after_load", int'(VGA), model_pix());

      // Reset mid-flash
      check("pre_reset_cnt", int'(dut.flash_cnt), m_cnt);
      check("pre_reset_vga", int'(VGA), 'h1FF);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_vga", int'(VGA), 0);
      check("rst_valid", int'(vga_valid), 0);
      check("rst_flash_cnt", int'(dut.flash_cnt), 0);
      rst = 1'b1;
      m_cnt = 0; m_id = 0; m_par = 0;
      probe(150, 60);
      check("post_reset_brick", int'(VGA), 'h1C0);

      // Randomized pixels against the model
      for (int n = 0; n < 400; n++) begin
         int bx0, by0, mode, px, py;
         state = 3'($urandom_range(0, 7));
         angle = 3'($urandom_range(0, 2));
         o_active = ($urandom_range(0, 9) != 0);
         bx0 = $urandom_range(0, 2047);
         by0 = $urandom_range(0, 1023);
         if (n % 4 == 0) bx0 = $urandom_range(0, 25);
         ball_x = {11'($urandom_range(0, 900)), 11'(bx0)};
         ball_y = {10'($urandom_range(0, 600)), 10'(by0)};
         ball_en = 2'($urandom_range(0, 3));
         x_paddle_r = 11'($urandom_range(0, 2047));
         x_paddle_l = 11'($urandom_range(0, 2047));
         if (n % 16 == 0) brick = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 9) == 0) pulse(1, $urandom_range(0, 1) == 1, $urandom_range(0, 63));
         if ($urandom_range(0, 4) == 0) pulse(0, 1, 0);
         mode = $urandom_range(0, 4);
         case (mode)
            0: begin px = clampi(bx0 + $urandom_range(0, 10) - 5, 2047);
                     py = clampi(by0 + $urandom_range(0, 10) - 5, 1023); end
            1: begin px = clampi((angle == 1 ? bx0 - 20 : bx0 + 20) + $urandom_range(0, 10) - 5, 2047);
                     py = clampi(by0 - 20 + $urandom_range(0, 10) - 5, 1023); end
            2: begin px = clampi(int'(x_paddle_r) + $urandom_range(0, 180) - 90, 2047);
                     py = $urandom_range(565, 585); end
            3: begin px = $urandom_range(0, 850); py = $urandom_range(0, 450); end
            default: begin px = $urandom_range(0, 2047); py = $urandom_range(0, 1023); end
         endcase
         probe_model("random", px, py);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
